// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches to a variable-latency in-order memory,
// buffers returned words for decode, and discards stale responses after redirects.
// Optional macro FETCH_PERF_EN adds stall and dropped-response counters.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_stall_cycles,
  output logic [31:0] o_perf_dropped
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic          halted;
  logic          trap_pend;
  logic [31:0]   trap_pc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] pq_wr, pq_rd;

  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  logic        fifo_trap [DEPTH];
  logic [31:0] pc_q      [DEPTH];

  logic [CW:0] occupancy;
  logic        empty;
  logic        req_fire;
  logic        rsp_legal;
  logic        rsp_keep;
  logic        rsp_discard;
  logic        push_marker;
  logic        push;
  logic        pop;
  logic        misaligned;

  // Handshakes: a transfer happens on any cycle where valid and ready are both high;
  // valid never waits on ready, and a raised request holds its address until taken.
  assign occupancy   = {1'b0, outstanding} + {1'b0, count};
  assign empty       = (count == '0);
  assign misaligned  = (i_redirect_pc[1:0] != 2'b00);

  assign o_imem_req_valid = !i_rst && !halted && !i_redirect && (occupancy < DEPTH_W);
  assign o_imem_req_addr  = fetch_pc;

  assign req_fire    = o_imem_req_valid && i_imem_req_ready;
  // A response with nothing outstanding is bogus and leaves all state alone.
  assign rsp_legal   = i_imem_rsp_valid && (outstanding != '0);
  assign rsp_keep    = rsp_legal && (drop == '0) && !i_redirect;
  assign rsp_discard = rsp_legal && !rsp_keep;
  assign push_marker = trap_pend && !i_redirect;
  assign push        = rsp_keep || push_marker;
  assign pop         = o_inst_valid && i_inst_ready;

  assign o_inst_valid = !empty;
  assign o_inst       = empty ? 32'd0 : fifo_inst[rd_ptr];
  assign o_inst_pc    = empty ? 32'd0 : fifo_pc[rd_ptr];
  assign o_inst_trap  = empty ? 1'b0  : fifo_trap[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc    <= RESET_ADDR;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      halted      <= 1'b0;
      trap_pend   <= 1'b0;
      trap_pc     <= 32'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_legal);
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        drop      <= outstanding - CW'(rsp_legal);
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        pq_wr     <= '0;
        pq_rd     <= '0;
        fetch_pc  <= {i_redirect_pc[31:2], 2'b00};
        halted    <= misaligned;
        trap_pend <= misaligned;
        trap_pc   <= i_redirect_pc;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
          pq_wr    <= pq_wr + 1'b1;
        end
        if (rsp_keep)    pq_rd  <= pq_rd + 1'b1;
        if (rsp_discard) drop   <= drop - 1'b1;
        if (push)        wr_ptr <= wr_ptr + 1'b1;
        if (pop)         rd_ptr <= rd_ptr + 1'b1;
        count     <= count + CW'(push) - CW'(pop);
        trap_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (req_fire) pc_q[pq_wr] <= fetch_pc;
    if (push) begin
      fifo_inst[wr_ptr] <= push_marker ? 32'd0 : i_imem_rsp_data;
      fifo_pc[wr_ptr]   <= push_marker ? trap_pc : pc_q[pq_rd];
      fifo_trap[wr_ptr] <= push_marker;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= 32'd0;
      drop_cnt  <= 32'd0;
    end else begin
      if (!o_inst_valid && !halted && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (rsp_discard && (drop_cnt != 32'hFFFF_FFFF))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign o_perf_stall_cycles = stall_cnt;
  assign o_perf_dropped      = drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory model plus a scoreboard of
// expected {trap, pc, inst} entries pushed when requests are accepted or redirects occur.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_trap;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_dropped;
`endif

  fetch_unit #(.RESET_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_inst_trap      (inst_trap),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_stall_cycles (perf_stall),
    .o_perf_dropped      (perf_dropped)
`endif
  );

  // clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1;
  logic        rr_rand = 1'b0, rr_fixed = 1'b1;
  logic        ir_rand = 1'b0, ir_fixed = 1'b1;
  logic        redir_pend = 1'b0;
  logic [31:0] redir_pc_pend = 32'd0;
  logic [31:0] exp_pc = 32'd0;
  logic        halted_m = 1'b0;
  int          n_req = 0;
  int          n_trap = 0;
  int          bubbles = 0;
  logic        track_bubbles = 1'b0, seen_first = 1'b0;
  logic        want_first = 1'b0;
  logic [31:0] first_pc = 32'd0;
  logic        last_req_valid, last_inst_valid, last_rsp_valid;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver: one clock cycle of stimulus, memory model and scoreboard update
  task automatic cycle();
    logic [64:0] e;
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mq_addr[0]);
    end
    req_ready   = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
    inst_ready  = ir_rand ? 1'($urandom_range(0, 1)) : ir_fixed;
    redirect    = redir_pend;
    redirect_pc = redir_pc_pend;
    #1;
    last_req_valid  = req_valid;
    last_req_addr   = req_addr;
    last_inst_valid = inst_valid;
    last_rsp_valid  = rsp_valid;
    if (rst) begin
      exp_q.delete();
      mq_addr.delete();
      mq_due.delete();
      exp_pc   = 32'h0000_0000;
      halted_m = 1'b0;
      last_due = 0;
    end else begin
      if (halted_m) check_eq("halt_noreq", 64'(req_valid), 64'd0);
      if (track_bubbles) begin
        if (seen_first && !inst_valid) bubbles++;
        if (inst_valid) seen_first = 1'b1;
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_inst", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("inst_trap", 64'(inst_trap), 64'(e[64]));
          check_eq("inst_pc",   64'(inst_pc),   64'(e[63:32]));
          check_eq("inst_word", 64'(inst),      64'(e[31:0]));
          if (inst_trap) n_trap++;
        end
        if (want_first) begin
          first_pc   = inst_pc;
          want_first = 1'b0;
        end
      end
      if (rsp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (req_valid && req_ready) begin
        int due;
        check_eq("req_addr", 64'(req_addr), 64'(exp_pc));
        due = cyc + int'($urandom_range(lat_min, lat_max));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_addr.push_back(req_addr);
        mq_due.push_back(due);
        exp_q.push_back({1'b0, req_addr, mem_word(req_addr)});
        exp_pc = exp_pc + 32'd4;
        n_req++;
      end
      if (redirect) begin
        exp_q.delete();
        exp_pc     = {redirect_pc[31:2], 2'b00};
        halted_m   = (redirect_pc[1:0] != 2'b00);
        want_first = 1'b1;
        if (halted_m) exp_q.push_back({1'b1, redirect_pc, 32'd0});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    redir_pend = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    run(n);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redir_pend    = 1'b1;
    redir_pc_pend = pc;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    @(posedge clk);
    #1;

    // reset state
    run(2);
    check_eq("rst_req_valid",  64'(req_valid),  64'd0);
    check_eq("rst_req_addr",   64'(req_addr),   64'h0);
    check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_inst",       64'(inst),       64'd0);
    check_eq("rst_inst_pc",    64'(inst_pc),    64'd0);
    check_eq("rst_inst_trap",  64'(inst_trap),  64'd0);
    rst = 1'b0;

    // streaming at latency 1
    n_req = 0; track_bubbles = 1'b1; seen_first = 1'b0; bubbles = 0;
    run(20);
    track_bubbles = 1'b0;
    check_eq("t1_reqs",    64'(n_req),   64'd20);
    check_eq("t1_bubbles", 64'(bubbles), 64'd0);

    // decode stalled, latency 3: fills exactly DEPTH slots
    do_reset(1);
    lat_min = 3; lat_max = 3; ir_fixed = 1'b0; n_req = 0;
    run(12);
    check_eq("t2_reqs",       64'(n_req),           64'd4);
    check_eq("t2_req_valid",  64'(last_req_valid),  64'd0);
    check_eq("t2_inst_valid", 64'(last_inst_valid), 64'd1);
    check_eq("t2_buffered",   64'(exp_q.size()),    64'd4);
    ir_fixed = 1'b1;
    run(8);
    check_eq("t2_resumed", 64'(n_req > 4), 64'd1);

    // redirect with two requests outstanding
    do_reset(1);
    lat_min = 4; lat_max = 4;
    rr_fixed = 1'b1;
    run(2);
    rr_fixed = 1'b0;
    check_eq("t3_outstanding", 64'(mq_addr.size()), 64'd2);
    do_redirect(32'h0000_0100);
    rr_fixed = 1'b1;
    run(15);
    check_eq("t3_first_pc", 64'(first_pc), 64'h100);
`ifdef FETCH_PERF_EN
    check_eq("t3_perf_dropped", 64'(perf_dropped), 64'd2);
`endif

    // redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    run(6);
    do_redirect(32'h0000_0300);
    check_eq("t4_rsp_and_pop", 64'({last_rsp_valid, last_inst_valid}), 64'b11);
    cycle();
    check_eq("t4_fifo_empty", 64'(last_inst_valid), 64'd0);
    check_eq("t4_req_valid",  64'(last_req_valid),  64'd1);
    check_eq("t4_req_addr",   64'(last_req_addr),   64'h300);
    run(6);

    // misaligned redirect: one trap marker, then halt until redirected
    n_trap = 0;
    do_redirect(32'h0000_0102);
    run(8);
    check_eq("t5_trap_seen", 64'(n_trap),       64'd1);
    check_eq("t5_first_pc",  64'(first_pc),     64'h102);
    check_eq("t5_sb_empty",  64'(exp_q.size()), 64'd0);
    do_redirect(32'h0000_0200);
    run(10);
    check_eq("t5_resume_pc", 64'(first_pc), 64'h200);

    // reset in the middle of a buffered stream
    ir_fixed = 1'b0;
    run(4);
    check_eq("t6_buffered", 64'(last_inst_valid), 64'd1);
    do_reset(1);
    cycle();
    check_eq("t6_inst_valid", 64'(last_inst_valid), 64'd0);
    check_eq("t6_req_valid",  64'(last_req_valid),  64'd1);
    check_eq("t6_req_addr",   64'(last_req_addr),   64'h0);

    // random traffic with random redirects
    lat_min = 1; lat_max = 4; rr_rand = 1'b1; ir_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        logic [31:0] pc;
        pc = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 3) == 0) pc = pc | 32'($urandom_range(1, 3));
        do_redirect(pc);
      end else begin
        cycle();
      end
    end

    // drain everything already requested
    rr_rand = 1'b0; rr_fixed = 1'b0; ir_rand = 1'b0; ir_fixed = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle();
    check_eq("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
